record_slot_sequencer: RTL and testbench

Upstream stage of the emulator's slot-parity toggle. It generates the free-running 2-bit slot phase `cnt` that the toggle stage consumes, and buffers 24-bit hit/data records in a small FIFO. It streams each record as three bytes in phases 0..2 of a 4-clock slot, with a K-character filler in phase 3. Byte outputs feed the 8b10b encoder.

---
 rtl/record_slot_sequencer.sv | 100 ++++++++++
 tb/tb_record_slot_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/record_slot_sequencer.sv
// Record slot sequencer: queues 24-bit records and streams each one as three
// bytes in phases 0..2 of a 4-clock slot, with a K filler byte in phase 3.
module record_slot_sequencer #(
  parameter int         DEPTH     = 4,
  parameter int         AW        = 2,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [23:0]   rec_data,
  input  logic          rec_valid,
  output logic          rec_ready,
  output logic [1:0]    cnt,
  output logic [7:0]    dout,
  output logic          dout_k,
  output logic          dout_valid,
  output logic [AW:0]   fifo_level,
  output logic          overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][23:0] mem;
  logic [AW-1:0]          wptr, rptr;
  logic [15:0]            tail;
  logic                   active;
  logic                   push, pop;
  logic [23:0]            head;

  assign rec_ready = (fifo_level != FULL);
  assign push      = rec_valid && rec_ready;
  // Boundary pop looks only at the registered level, so a same-edge push waits a slot.
  assign pop       = enable && (cnt == 2'd3) && (fifo_level != '0);
  assign head      = mem[rptr];

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= rec_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      cnt        <= 2'd0;
      dout       <= IDLE_BYTE;
      dout_k     <= 1'b1;
      dout_valid <= 1'b0;
      tail       <= '0;
      active     <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (rec_valid && !rec_ready) overflow <= 1'b1;

      if (enable) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd3: begin
            if (pop) begin
              dout       <= head[23:16];
              dout_k     <= 1'b0;
              dout_valid <= 1'b1;
              tail       <= head[15:0];
              active     <= 1'b1;
            end else begin
              dout       <= IDLE_BYTE;
              dout_k     <= 1'b1;
              dout_valid <= 1'b0;
              active     <= 1'b0;
            end
          end
          2'd0: begin
            dout       <= active ? tail[15:8] : IDLE_BYTE;
            dout_k     <= !active;
            dout_valid <= active;
          end
          2'd1: begin
            dout       <= active ? tail[7:0] : IDLE_BYTE;
            dout_k     <= !active;
            dout_valid <= active;
          end
          default: begin
            dout       <= IDLE_BYTE;
            dout_k     <= 1'b1;
            dout_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_record_slot_sequencer.sv
// Bench for record_slot_sequencer: directed scenarios plus random traffic,
// checked every cycle against a queue-based slot model.
module tb_record_slot_sequencer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clock = 1'b0;
  logic          reset, enable, rec_valid;
  logic [23:0]   rec_data;
  logic          rec_ready, dout_k, dout_valid, overflow;
  logic [1:0]    cnt;
  logic [7:0]    dout;
  logic [AW:0]   fifo_level;

  record_slot_sequencer #(.DEPTH(DEPTH), .AW(AW), .IDLE_BYTE(8'hBC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rec_data(rec_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .cnt(cnt), .dout(dout),
    .dout_k(dout_k), .dout_valid(dout_valid), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a record queue, the record owning the current slot, and the phase.
  logic [23:0] mq[$];
  logic [23:0] m_cur;
  bit          m_act;
  int          m_cnt;
  logic [7:0]  m_dout;
  bit          m_k, m_v, m_ovf;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic en, input logic rv, input logic [23:0] rd);
    int sz;
    logic [23:0] sh;
    if (!rst) begin
      mq.delete();
      m_cnt = 0; m_act = 0; m_cur = '0;
      m_dout = 8'hBC; m_k = 1; m_v = 0; m_ovf = 0;
      return;
    end
    sz = mq.size();
    if (en) begin
      if (m_cnt == 3) begin
        if (sz > 0) begin m_cur = mq.pop_front(); m_act = 1; end
        else m_act = 0;
      end
      m_cnt = (m_cnt + 1) % 4;
      if (m_cnt < 3 && m_act) begin
        sh = m_cur >> (8 * (2 - m_cnt));
        m_dout = sh[7:0]; m_k = 0; m_v = 1;
      end else begin
        m_dout = 8'hBC; m_k = 1; m_v = 0;
      end
    end
    if (rv) begin
      if (sz < DEPTH) mq.push_back(rd);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic rv, input logic [23:0] rd);
    reset = rst; enable = en; rec_valid = rv; rec_data = rd;
    @(posedge clock);
    model_edge(rst, en, rv, rd);
    #1;
    chk("cnt",        int'(cnt),        m_cnt);
    chk("dout",       int'(dout),       int'(m_dout));
    chk("dout_k",     int'(dout_k),     int'(m_k));
    chk("dout_valid", int'(dout_valid), int'(m_v));
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("rec_ready",  int'(rec_ready),  int'(mq.size() != DEPTH));
    chk("overflow",   int'(overflow),   int'(m_ovf));
  endtask

  task automatic idle_steps(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1, en, 0, 24'h0);
  endtask

  task automatic run_to_cnt(input int target, input string tag);
    int b;
    b = 0;
    while (m_cnt != target && b < 8) begin step(1, 1, 0, 24'h0); b++; end
    if (m_cnt != target) chk({tag, "_timeout"}, m_cnt, target);
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    while (mq.size() != 0 && b < 64) begin step(1, 1, 0, 24'h0); b++; end
    idle_steps(4, 1);
    if (mq.size() != 0) chk({tag, "_timeout"}, mq.size(), 0);
  endtask

  initial begin
    reset = 0; enable = 0; rec_valid = 0; rec_data = '0;
    m_cnt = 0; m_act = 0; m_cur = '0; m_dout = 8'hBC; m_k = 1; m_v = 0; m_ovf = 0;
    #2;
    step(0, 0, 0, 24'h0);
    step(0, 1, 0, 24'h0);
    chk("rst_dout",  int'(dout), 8'hBC);
    chk("rst_level", int'(fifo_level), 0);

    // 1: free-running idle
    idle_steps(10, 1);

    // 2: single record pushed at cnt==1
    run_to_cnt(1, "s2");
    step(1, 1, 1, 24'hA1B2C3);
    idle_steps(10, 1);

    // 3: fill while stalled, one dropped, then stream
    drain("s3");
    for (int i = 0; i < 5; i++) step(1, 0, 1, 24'h100000 * (i + 1) + 24'h0A0B0C);
    chk("s3_ovf", int'(overflow), 1);
    idle_steps(20, 1);

    // 4: push into empty FIFO at the boundary edge
    drain("s4");
    run_to_cnt(3, "s4");
    step(1, 1, 1, 24'h112233);
    idle_steps(10, 1);

    // 5: stall mid-record
    drain("s5");
    step(1, 1, 1, 24'hA1B2C3);
    begin
      int b;
      b = 0;
      while (!(m_cnt == 1 && m_v) && b < 16) begin step(1, 1, 0, 24'h0); b++; end
      chk("s5_sync", int'(m_cnt == 1 && m_v), 1);
    end
    idle_steps(5, 0);
    idle_steps(4, 1);

    // 6: reset mid-slot with queued records and overflow set
    for (int i = 0; i < 3; i++) step(1, 0, 1, 24'hC0FFE0 + 24'(i));
    begin
      int b;
      b = 0;
      while (!(m_cnt == 2 && m_v) && b < 16) begin step(1, 1, 0, 24'h0); b++; end
    end
    step(0, 1, 0, 24'h0);
    chk("s6_cnt",   int'(cnt), 0);
    chk("s6_level", int'(fifo_level), 0);
    chk("s6_ovf",   int'(overflow), 0);
    chk("s6_k",     int'(dout_k), 1);
    idle_steps(8, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, e, v;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) < 8);
      v = ($urandom_range(0, 9) < 4);
      step(r, e, v, 24'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
